dmem_copy_engine: RTL and testbench

//  Initiator for the single-port data memory: drives the address, write-enable and write-data.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_copy_engine.sv | 102 ++++++++++
 tb/tb_dmem_copy_engine.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and default sizes for the data-memory copy engine.
package dmem_pkg;

    localparam int DMEM_W = 8;
    localparam int DMEM_D = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } copy_state_t;

endpackage

// File: rtl/dmem_copy_engine.sv
// Block-move helper for the single-port data memory: copies Len words from
// SrcAddr to DstAddr, one read cycle and one write cycle per word, ascending,
// and accumulates a mod-2**W checksum of the words moved.
module dmem_copy_engine
    import dmem_pkg::*;
#(
    parameter int W = DMEM_W,
    parameter int D = DMEM_D
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [D-1:0] SrcAddr,
    input  logic [D-1:0] DstAddr,
    input  logic [D-1:0] Len,
    output logic         Busy,
    output logic         Done,
    output logic [W-1:0] Checksum,
    output logic [D-1:0] MemAddr,
    output logic         MemWriteEn,
    output logic [W-1:0] MemWrData,
    input  logic [W-1:0] MemRdData
);

    copy_state_t  state_q;
    logic [D-1:0] src_q;
    logic [D-1:0] dst_q;
    logic [D-1:0] rem_q;
    logic [W-1:0] data_q;
    logic [W-1:0] sum_q;

    // Copy FSM with pointers, word counter, data holding register and checksum.
    // Pointers wrap naturally at 2**D; reset discards any partial checksum.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            sum_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        sum_q <= '0;
                        if (Len != '0) begin
                            src_q   <= SrcAddr;
                            dst_q   <= DstAddr;
                            rem_q   <= Len;
                            state_q <= RD;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                RD: begin
                    data_q  <= MemRdData;
                    sum_q   <= sum_q + MemRdData;
                    state_q <= WR;
                end
                WR: begin
                    src_q   <= src_q + 1'b1;
                    dst_q   <= dst_q + 1'b1;
                    rem_q   <= rem_q - 1'b1;
                    state_q <= (rem_q > 1) ? RD : DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory port and status decode from state and registers only, so an
    // async reset drops MemWriteEn in the same cycle.
    always_comb begin
        MemAddr    = '0;
        MemWriteEn = 1'b0;
        MemWrData  = '0;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state_q)
            RD: begin
                MemAddr = src_q;
                Busy    = 1'b1;
            end
            WR: begin
                MemAddr    = dst_q;
                MemWriteEn = 1'b1;
                MemWrData  = data_q;
                Busy       = 1'b1;
            end
            DONE:    Done = 1'b1;
            default: ;
        endcase
    end

    assign Checksum = sum_q;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Directed bench for dmem_copy_engine paired with a combinational-read,
// posedge-write data memory model.
module tb_dmem_copy_engine;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic [7:0] SrcAddr = '0;
    logic [7:0] DstAddr = '0;
    logic [7:0] Len = '0;
    logic       Busy;
    logic       Done;
    logic [7:0] Checksum;
    logic [7:0] MemAddr;
    logic       MemWriteEn;
    logic [7:0] MemWrData;
    logic [7:0] MemRdData;

    logic [7:0] mem [256];
    logic       mem_clr = 1'b0;
    logic       pl_en = 1'b0;
    logic [7:0] pl_addr = '0;
    logic [7:0] pl_data = '0;
    int         wr_edges = 0;

    int n_chk = 0;
    int n_err = 0;

    dmem_copy_engine #(.W(8), .D(8)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .SrcAddr    (SrcAddr),
        .DstAddr    (DstAddr),
        .Len        (Len),
        .Busy       (Busy),
        .Done       (Done),
        .Checksum   (Checksum),
        .MemAddr    (MemAddr),
        .MemWriteEn (MemWriteEn),
        .MemWrData  (MemWrData),
        .MemRdData  (MemRdData)
    );

    always #5 Clk = ~Clk;

    // Data memory model: combinational read, posedge write; bench preload port.
    assign MemRdData = mem[MemAddr];
    always @(posedge Clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (MemWriteEn) begin
            mem[MemAddr] <= MemWrData;
            wr_edges     <= wr_edges + 1;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge Clk); #1;
        pl_en = 1'b0;
    endtask

    // Launch a copy and watch it; 'pk' > 0 re-pulses Start in that cycle.
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                            input int pk, output int done_cyc, output int busy_cyc,
                            output int n_done);
        Start = 1'b1; SrcAddr = s; DstAddr = d; Len = l;
        @(posedge Clk); #1;
        Start = 1'b0; SrcAddr = 8'hEE; DstAddr = 8'hEE; Len = 8'h07;
        done_cyc = 0; busy_cyc = 0; n_done = 0;
        for (int c = 1; c <= 600; c++) begin
            if (c == pk) begin
                Start = 1'b1; SrcAddr = 8'd200; DstAddr = 8'd201; Len = 8'd1;
            end else begin
                Start = 1'b0;
            end
            if (Busy) busy_cyc++;
            if (Done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (done_cyc != 0 && c >= done_cyc + 4) break;
            @(posedge Clk); #1;
        end
        Start = 1'b0;
    endtask

    int dc, bc, nd, w0;

    initial begin
        // reset state
        mem_clr = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        mem_clr = 1'b0;
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_sum", Checksum, 0);
        chk("rst_addr", MemAddr, 0);
        chk("rst_we", MemWriteEn, 0);
        chk("rst_wd", MemWrData, 0);
        Reset = 1'b1;
        @(posedge Clk); #1;

        // 1: basic copy of four words
        poke(16, 1); poke(17, 2); poke(18, 3); poke(19, 4);
        run_copy(16, 32, 4, 0, dc, bc, nd);
        chk("t1_done_cyc", dc, 9);
        chk("t1_busy_cyc", bc, 8);
        chk("t1_ndone", nd, 1);
        chk("t1_sum", Checksum, 10);
        chk("t1_m32", mem[32], 1);
        chk("t1_m33", mem[33], 2);
        chk("t1_m34", mem[34], 3);
        chk("t1_m35", mem[35], 4);
        chk("t1_idle_addr", MemAddr, 0);

        // 2: zero-length copy
        w0 = wr_edges;
        run_copy(5, 6, 0, 0, dc, bc, nd);
        chk("t2_done_cyc", dc, 1);
        chk("t2_busy_cyc", bc, 0);
        chk("t2_no_write", wr_edges - w0, 0);
        chk("t2_sum", Checksum, 0);

        // 3: source pointer wraps past 0xFF
        poke(254, 8'hAA); poke(255, 8'hBB); poke(0, 8'hCC);
        run_copy(254, 100, 3, 0, dc, bc, nd);
        chk("t3_done_cyc", dc, 7);
        chk("t3_m100", mem[100], 8'hAA);
        chk("t3_m101", mem[101], 8'hBB);
        chk("t3_m102", mem[102], 8'hCC);
        chk("t3_sum", Checksum, 8'h31);

        // 4: dst = src+1 overlap replicates the first word
        poke(10, 7); poke(11, 9); poke(12, 0);
        run_copy(10, 11, 2, 0, dc, bc, nd);
        chk("t4_m11", mem[11], 7);
        chk("t4_m12", mem[12], 7);
        chk("t4_sum", Checksum, 14);

        // 5: Start re-pulsed while busy is ignored
        for (int i = 0; i < 5; i++) poke(8'(i), 8'(i + 1));
        poke(201, 8'h5A);
        w0 = wr_edges;
        run_copy(0, 64, 5, 3, dc, bc, nd);
        chk("t5_done_cyc", dc, 11);
        chk("t5_ndone", nd, 1);
        chk("t5_writes", wr_edges - w0, 5);
        chk("t5_sum", Checksum, 15);
        chk("t5_m64", mem[64], 1);
        chk("t5_m68", mem[68], 5);
        chk("t5_m201", mem[201], 8'h5A);
        repeat (3) @(posedge Clk);
        #1;
        chk("t5_sum_hold", Checksum, 15);

        // 6: async reset during the second word's write
        poke(82, 8'h55); poke(83, 8'h66);
        Start = 1'b1; SrcAddr = 16; DstAddr = 80; Len = 4;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("t6_we_before", MemWriteEn, 1);
        chk("t6_addr_before", MemAddr, 81);
        #2 Reset = 1'b0;
        #1;
        chk("t6_we_after", MemWriteEn, 0);
        chk("t6_busy_after", Busy, 0);
        chk("t6_sum_after", Checksum, 0);
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        chk("t6_m80", mem[80], 1);
        chk("t6_m81", mem[81], 0);
        chk("t6_m82", mem[82], 8'h55);
        chk("t6_m83", mem[83], 8'h66);
        chk("t6_idle_busy", Busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
